qoi_seg_sequencer: RTL and testbench

- Sequences one qoi_rgb444_encoder instance per camera frame.
- Splits the OV7670 RGB444 pixel stream into segments. For each segment it resets the encoder, feeds pixels one per EN_PERIOD cycles, closes the segment on pixel count, encoder cap or end of frame, then drains the encoder's byte buffer.
- The drained bytes go out as a length-prefixed byte stream toward the UART/storage FIFO.
- Sits between the pixel capture front end and the encoder/output mux.

---
 rtl/qoi_seg_sequencer.sv | 130 +++++++++++++
 tb/tb_qoi_seg_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qoi_seg_sequencer.sv
// qoi_seg_sequencer: cuts a camera frame into encoder segments and streams each
// segment's encoder buffer out as a length-prefixed byte stream.
module qoi_seg_sequencer #(
  parameter int SEG_PIXELS = 64,
  parameter int BUF_BYTES  = 320,
  parameter int EN_PERIOD  = 2,
  parameter int FLUSH_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sof,
  input  logic        pix_valid,
  input  logic [11:0] pix_rgb,
  input  logic        pix_last,
  output logic        pix_ready,
  output logic        enc_rst_n,
  output logic        enc_en,
  output logic [11:0] enc_rgb,
  input  logic        enc_capped,
  input  logic [8:0]  enc_len,
  output logic [8:0]  rd_idx,
  input  logic [7:0]  rd_byte,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_done,
  output logic        aborted
);
  localparam int CW = $clog2(SEG_PIXELS + 1);
  localparam int PW = $clog2(EN_PERIOD + 1);
  localparam int FW = $clog2(FLUSH_LAT + 1);
  typedef enum logic [2:0] {IDLE, ERST, FEED, FLUSH, HDR, DRAIN} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [PW-1:0] phase;
  logic [FW-1:0] fcnt;
  logic [8:0] len, len_sat;
  logic hsel, eof_seen, en_d;
  logic abort, close, hs, acc, done, flush_done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = sof ? ERST : IDLE;
      ERST:    nxt = FEED;
      FEED:    nxt = close ? FLUSH : FEED;
      FLUSH:   nxt = flush_done ? HDR : FLUSH;
      HDR:     nxt = done ? (eof_seen ? IDLE : ERST) : (acc && hsel) ? DRAIN : HDR;
      DRAIN:   nxt = done ? (eof_seen ? IDLE : ERST) : DRAIN;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = ERST;
  end
  // The close check runs one cycle after each encoder step so enc_capped reflects that pixel.
  always_comb begin
    abort      = sof && state != IDLE;
    close      = state == FEED && en_d && (cnt == CW'(SEG_PIXELS) || enc_capped || eof_seen);
    pix_ready  = state == FEED && phase == '0 && !close && !sof;
    hs         = pix_valid && pix_ready;
    acc        = out_valid && out_ready;
    done       = acc && out_last;
    flush_done = state == FLUSH && fcnt == FW'(FLUSH_LAT - 1);
    len_sat    = enc_len > 9'(BUF_BYTES) ? 9'(BUF_BYTES) : enc_len;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_rst_n  <= 1'b0;
      enc_en     <= 1'b0;
      enc_rgb    <= '0;
      en_d       <= 1'b0;
      cnt        <= '0;
      phase      <= '0;
      fcnt       <= '0;
      len        <= '0;
      eof_seen   <= 1'b0;
      hsel       <= 1'b0;
      rd_idx     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      enc_rst_n  <= nxt != ERST;
      enc_en     <= hs;
      en_d       <= enc_en;
      aborted    <= abort;
      frame_done <= done && eof_seen && !abort;
      if (hs) enc_rgb <= pix_rgb;
      if (nxt == ERST) cnt <= '0;
      else if (hs) cnt <= cnt + 1'b1;
      // Phase only leaves 0 on a handshake, so an idle pixel input never builds up a bubble.
      if (state != FEED) phase <= '0;
      else if (hs || phase != '0) phase <= (phase == PW'(EN_PERIOD - 1)) ? '0 : phase + 1'b1;
      fcnt <= (state == FLUSH) ? fcnt + 1'b1 : '0;
      if (flush_done) len <= len_sat;
      if (abort || done) eof_seen <= 1'b0;
      else if (hs) eof_seen <= pix_last;
      // rd_idx leads out_data by one byte because rd_byte is a combinational lookup.
      if (abort) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        hsel      <= 1'b0;
        rd_idx    <= '0;
      end else if (flush_done) begin
        out_valid <= 1'b1;
        out_data  <= {7'b0, len_sat[8]};
        out_last  <= 1'b0;
        hsel      <= 1'b0;
        rd_idx    <= '0;
      end else if (acc) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else if (!hsel) begin
          out_data <= len[7:0];
          out_last <= len == 9'd0;
          hsel     <= 1'b1;
        end else begin
          out_data <= rd_byte;
          out_last <= rd_idx == len - 9'd1;
          rd_idx   <= (rd_idx == len - 9'd1) ? rd_idx : rd_idx + 9'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_qoi_seg_sequencer.sv
// tb_qoi_seg_sequencer: directed frames with a byte scoreboard and a small encoder model.
module tb_qoi_seg_sequencer;
  logic clk = 0, rst_n = 0, sof = 0, pix_valid = 0, pix_last = 0, out_ready = 1;
  logic enc_capped;
  logic [11:0] pix_rgb = '0;
  logic [8:0] enc_len = '0;
  logic pix_ready, enc_rst_n, enc_en, out_valid, out_last, frame_done, aborted;
  logic [11:0] enc_rgb;
  logic [8:0] rd_idx;
  logic [7:0] rd_byte, out_data;
  assign rd_byte = rd_idx[7:0] ^ 8'h3C;
  always #5 clk = ~clk;

  qoi_seg_sequencer dut (
    .clk(clk), .rst_n(rst_n), .sof(sof), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
    .pix_last(pix_last), .pix_ready(pix_ready), .enc_rst_n(enc_rst_n), .enc_en(enc_en),
    .enc_rgb(enc_rgb), .enc_capped(enc_capped), .enc_len(enc_len), .rd_idx(rd_idx),
    .rd_byte(rd_byte), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .frame_done(frame_done), .aborted(aborted)
  );

  typedef struct {logic [7:0] d; logic l; int en;} exp_t;
  exp_t exp_q[$];
  logic [11:0] pix_q[$];
  int checks = 0, errors = 0;
  int en_cnt = 0, en_total = 0, gap = 0, low_run = 0, pops = 0, fd_cnt = 0, ab_cnt = 0;
  bit cap_on = 0, bp_on = 0, stall = 0;
  logic [8:0] stall_v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Encoder stand-in: checks pixel order/cadence, raises enc_capped after 20 steps when enabled.
  always @(negedge clk) begin
    if (!enc_rst_n) begin
      en_cnt = 0;
      gap = 0;
    end else if (enc_en) begin
      if (en_cnt > 0) chk("en_gap", gap, 2);
      if (pix_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL enc_en_without_pixel: got enc_en expected none");
      end else chk("enc_rgb", enc_rgb, pix_q.pop_front());
      en_cnt++;
      en_total++;
      gap = 1;
    end else gap++;
    enc_capped = cap_on && en_cnt >= 20;
    if (!rst_n) low_run = 0;
    else if (!enc_rst_n) low_run++;
    else begin
      if (low_run > 0) chk("erst_len", low_run, 1);
      low_run = 0;
    end
    if (frame_done) fd_cnt++;
    if (aborted) ab_cnt++;
  end

  // Output monitor: pops the scoreboard on every accepted byte and checks stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && stall) chk("stall_stable", {out_last, out_data}, stall_v);
    stall = out_valid && !out_ready;
    stall_v = {out_last, out_data};
    if (out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_byte: got %0h expected no byte", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_byte", {out_last, out_data}, {e.l, e.d});
        if (e.en >= 0) chk("seg_pixels", en_cnt, e.en);
      end
    end
  end

  always @(posedge clk) begin
    #1 out_ready = bp_on ? !out_ready : 1'b1;
  end

  task automatic push_seg(input int en, input logic [7:0] h0, input logic [7:0] h1, input int n);
    logic [7:0] b;
    exp_q.push_back('{d: h0, l: 1'b0, en: en});
    exp_q.push_back('{d: h1, l: n == 0, en: -1});
    for (int i = 0; i < n; i++) begin
      b = i[7:0] ^ 8'h3C;
      exp_q.push_back('{d: b, l: i == n - 1, en: -1});
    end
  endtask

  task automatic pulse_sof;
    @(posedge clk); #1 sof = 1;
    @(posedge clk); #1 sof = 0;
  endtask

  task automatic feed(input int n, input bit last, input bit hold, input logic [11:0] base, input int step);
    int i = 0, t = 0;
    bit h;
    @(posedge clk); #1 pix_valid = 1;
    while (i < n && t < 2000) begin
      pix_rgb = base + 12'(i * step);
      pix_last = last && i == n - 1;
      @(negedge clk); h = pix_ready;
      @(posedge clk); #1;
      if (h) begin
        pix_q.push_back(pix_rgb);
        i++;
      end
      t++;
    end
    checks++;
    if (i != n) begin
      errors++;
      $display("FAIL feed: accepted %0d pixels expected %0d", i, n);
    end
    if (!hold) begin
      pix_valid = 0;
      pix_last = 0;
    end
  endtask

  task automatic wait_empty(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
    pix_valid = 0;
  endtask

  initial begin
    int p0, t, e0;
    bit rdy;
    repeat (2) @(posedge clk);
    #1 chk("reset_state", {enc_rst_n, enc_en, enc_rgb, pix_ready, rd_idx, out_valid, out_data, out_last, frame_done, aborted}, 64'd0);
    @(posedge clk); #3 rst_n = 1;
    repeat (3) @(posedge clk);
    // Frame 1: full 64-pixel segment, then a 10-pixel end-of-frame segment
    enc_len = 9'd9;
    push_seg(64, 8'h00, 8'h09, 9);
    pulse_sof;
    feed(64, 0, 0, 12'hFFF, 0);
    wait_empty(500);
    enc_len = 9'd5;
    push_seg(10, 8'h00, 8'h05, 5);
    feed(10, 1, 0, 12'h123, 7);
    wait_empty(300);
    repeat (3) @(posedge clk);
    chk("frame_done_f1", fd_cnt, 1);
    // Frame 2: encoder cap after 20 pixels with toggling out_ready, then abort mid-drain
    enc_len = 9'd300;
    cap_on = 1;
    bp_on = 1;
    push_seg(20, 8'h01, 8'h2C, 300);
    pulse_sof;
    @(negedge clk); #1 chk("no_abort_from_idle", ab_cnt, 0);
    feed(20, 0, 1, 12'h800, 3);
    wait_empty(2000);
    cap_on = 0;
    bp_on = 0;
    enc_len = 9'd40;
    push_seg(5, 8'h00, 8'h28, 40);
    feed(5, 1, 0, 12'h0F0, 1);
    p0 = pops;
    t = 0;
    while (pops < p0 + 14 && t < 500) begin
      @(negedge clk); #1;
      t++;
    end
    checks++;
    if (pops < p0 + 14) begin
      errors++;
      $display("FAIL abort_setup: got %0d bytes expected %0d", pops - p0, 14);
    end
    @(posedge clk); #1 sof = 1;
    @(posedge clk); #1;
    chk("abort_pulse", aborted, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_enc_rst_n", enc_rst_n, 0);
    sof = 0;
    exp_q.delete();
    // Frame 3 (started by the aborting sof): zero-length segment
    enc_len = 9'd0;
    push_seg(6, 8'h00, 8'h00, 0);
    feed(6, 1, 0, 12'hABC, 5);
    wait_empty(200);
    repeat (3) @(posedge clk);
    chk("frame_done_f3", fd_cnt, 2);
    chk("aborted_count", ab_cnt, 1);
    // Frame 4: asynchronous reset in the middle of FEED
    enc_len = 9'd7;
    pulse_sof;
    feed(12, 0, 1, 12'h5A5, 0);
    @(posedge clk); #3 rst_n = 0;
    pix_valid = 0;
    #1 chk("async_reset", {enc_rst_n, enc_en, enc_rgb, pix_ready, rd_idx, out_valid, out_data, out_last, frame_done, aborted}, 64'd0);
    pix_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    pix_valid = 1;
    e0 = en_total;
    rdy = 0;
    repeat (10) begin
      @(negedge clk);
      rdy |= pix_ready;
    end
    pix_valid = 0;
    chk("idle_no_enc_en", en_total - e0, 0);
    chk("idle_no_ready", rdy, 0);
    // Frame 5: pix_last on the 64th pixel, oversized enc_len saturates to 320
    enc_len = 9'h1F0;
    push_seg(64, 8'h01, 8'h40, 320);
    pulse_sof;
    feed(64, 1, 0, 12'h001, 1);
    wait_empty(800);
    repeat (3) @(posedge clk);
    chk("frame_done_f5", fd_cnt, 3);
    chk("aborted_final", ab_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
